nco_mode_sequencer: RTL and testbench

//  Parametrised successor to the NCO front-panel sequencer. Walks the user through signal

---
 rtl/nco_mode_sequencer_pkg.sv | 18 +
 rtl/nco_mode_sequencer_delay_timer.sv | 29 ++
 rtl/nco_mode_sequencer.sv | 111 +++++++++++
 tb/tb_nco_mode_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nco_mode_sequencer_pkg.sv
// State encoding for the NCO front-panel sequencer, shared with the display driver
// that decodes state_out.
package nco_ui_pkg;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_SIG_SEL  = 3'd1,
    S_SIG_SHOW = 3'd2,
    S_FRQ_SEL  = 3'd3,
    S_FRQ_SHOW = 3'd4,
    S_RUN      = 3'd5
  } ui_state_e;

  function automatic logic is_delay_state(input logic [2:0] s);
    return (s == S_RESET) || (s == S_SIG_SHOW) || (s == S_FRQ_SHOW);
  endfunction

endpackage

// File: rtl/nco_mode_sequencer_delay_timer.sv
// Hold timer for the display/reset states: counts while enabled and pulses done on
// the last cycle of the hold window.
module ui_delay_timer #(
  parameter int DELAY_CYCLES = 10
) (
  input  logic clk_1MHz,
  input  logic rst,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(DELAY_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  assign done = en && (r_cnt == CNT_W'(DELAY_CYCLES - 1));

  // Clearing on done keeps the count at zero in the following non-delay state.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nco_mode_sequencer.sv
// Front-panel sequencer: signal select/show, frequency select/show, then run with
// latched indices, a one-shot config-load strobe and re-entry from run.
module nco_mode_sequencer
  import nco_ui_pkg::*;
#(
  parameter int CLK_HZ      = 1_000_000,
  parameter int DISPLAY_SEC = 5,
  parameter int N_SIGNALS   = 4,
  parameter int N_FREQS     = 8
) (
  input  logic                         clk_1MHz,
  input  logic                         rst,
  input  logic                         signal_select,
  input  logic                         freq_select,
  input  logic                         next_btn,
  output logic [2:0]                   state_out,
  output logic [$clog2(N_SIGNALS)-1:0] sig_idx,
  output logic [$clog2(N_FREQS)-1:0]   freq_idx,
  output logic                         cfg_valid,
  output logic                         cfg_load,
  output logic                         delay_active
);

  localparam int DELAY_CYCLES = CLK_HZ * DISPLAY_SEC;
  localparam int SIG_W        = $clog2(N_SIGNALS);
  localparam int FRQ_W        = $clog2(N_FREQS);

  if (DELAY_CYCLES < 2) begin : g_bad_delay
    $error("nco_mode_sequencer: DELAY_CYCLES must be >= 2");
  end

  logic             r_sig_h, r_frq_h, r_nxt_h;
  logic [2:0]       r_state, w_nxt_state;
  logic [SIG_W-1:0] r_sig_idx, w_sig_idx_nxt;
  logic [FRQ_W-1:0] r_frq_idx, w_frq_idx_nxt;
  logic             r_cfg_valid, r_cfg_load, r_delay_active;
  logic             w_sig_rise, w_frq_rise, w_nxt_rise;
  logic             w_delay_en, w_done;

  assign w_sig_rise = signal_select & ~r_sig_h;
  assign w_frq_rise = freq_select & ~r_frq_h;
  assign w_nxt_rise = next_btn & ~r_nxt_h;
  assign w_delay_en = is_delay_state(r_state);

  ui_delay_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_timer (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .en       (w_delay_en),
    .done     (w_done)
  );

  // A confirm edge takes priority over a simultaneous step edge.
  always_comb begin
    w_nxt_state   = r_state;
    w_sig_idx_nxt = r_sig_idx;
    w_frq_idx_nxt = r_frq_idx;
    case (r_state)
      S_RESET:    if (w_done) w_nxt_state = S_SIG_SEL;
      S_SIG_SEL: begin
        if (w_sig_rise) w_nxt_state = S_SIG_SHOW;
        else if (w_nxt_rise)
          w_sig_idx_nxt = (r_sig_idx == SIG_W'(N_SIGNALS - 1)) ? '0 : r_sig_idx + SIG_W'(1);
      end
      S_SIG_SHOW: if (w_done) w_nxt_state = S_FRQ_SEL;
      S_FRQ_SEL: begin
        if (w_frq_rise) w_nxt_state = S_FRQ_SHOW;
        else if (w_nxt_rise)
          w_frq_idx_nxt = (r_frq_idx == FRQ_W'(N_FREQS - 1)) ? '0 : r_frq_idx + FRQ_W'(1);
      end
      S_FRQ_SHOW: if (w_done) w_nxt_state = S_RUN;
      S_RUN: begin
        if (w_sig_rise)      w_nxt_state = S_SIG_SEL;
        else if (w_frq_rise) w_nxt_state = S_FRQ_SEL;
      end
      default:    w_nxt_state = S_RESET;
    endcase
  end

  // History regs reset high so a button held through reset produces no edge.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_state        <= S_RESET;
      r_sig_idx      <= '0;
      r_frq_idx      <= '0;
      r_sig_h        <= 1'b1;
      r_frq_h        <= 1'b1;
      r_nxt_h        <= 1'b1;
      r_cfg_valid    <= 1'b0;
      r_cfg_load     <= 1'b0;
      r_delay_active <= 1'b1;
    end else begin
      r_state        <= w_nxt_state;
      r_sig_idx      <= w_sig_idx_nxt;
      r_frq_idx      <= w_frq_idx_nxt;
      r_sig_h        <= signal_select;
      r_frq_h        <= freq_select;
      r_nxt_h        <= next_btn;
      r_cfg_valid    <= (w_nxt_state == S_RUN);
      r_cfg_load     <= (w_nxt_state == S_RUN) && (r_state != S_RUN);
      r_delay_active <= is_delay_state(w_nxt_state);
    end
  end

  assign state_out    = r_state;
  assign sig_idx      = r_sig_idx;
  assign freq_idx     = r_frq_idx;
  assign cfg_valid    = r_cfg_valid;
  assign cfg_load     = r_cfg_load;
  assign delay_active = r_delay_active;

endmodule

// File: tb/tb_nco_mode_sequencer.sv
// Scoreboard bench for nco_mode_sequencer with a 10-cycle hold window.
module tb_nco_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s = 1'b0, f = 1'b0, n = 1'b0;
  logic [2:0] state_out;
  logic [1:0] sig_idx;
  logic [2:0] freq_idx;
  logic       cfg_valid, cfg_load, delay_active;

  nco_mode_sequencer #(
    .CLK_HZ(10), .DISPLAY_SEC(1), .N_SIGNALS(4), .N_FREQS(8)
  ) dut (
    .clk_1MHz      (clk),
    .rst           (rst),
    .signal_select (s),
    .freq_select   (f),
    .next_btn      (n),
    .state_out     (state_out),
    .sig_idx       (sig_idx),
    .freq_idx      (freq_idx),
    .cfg_valid     (cfg_valid),
    .cfg_load      (cfg_load),
    .delay_active  (delay_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    string      nm;
    logic [2:0] st;
    logic [1:0] si;
    logic [2:0] fi;
    logic       cv, cl, da;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that is due this cycle and compares at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      n_total++;
      if (e.at != cyc)
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.nm, e.at, cyc);
      else if (state_out !== e.st || sig_idx !== e.si || freq_idx !== e.fi ||
               cfg_valid !== e.cv || cfg_load !== e.cl || delay_active !== e.da)
        $display("FAIL %s: got st=%0d si=%0d fi=%0d cv=%b cl=%b da=%b, want st=%0d si=%0d fi=%0d cv=%b cl=%b da=%b",
                 e.nm, state_out, sig_idx, freq_idx, cfg_valid, cfg_load, delay_active,
                 e.st, e.si, e.fi, e.cv, e.cl, e.da);
      else
        n_pass++;
    end
  end

  task automatic chk(input string nm, input logic [2:0] st, input logic [1:0] si,
                     input logic [2:0] fi, input logic cv, input logic cl, input logic da);
    exp_t e;
    e.at = cyc; e.nm = nm; e.st = st; e.si = si; e.fi = fi;
    e.cv = cv; e.cl = cl; e.da = da;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ps, input logic pf, input logic pn);
    s = ps; f = pf; n = pn;
    tick();
    s = 1'b0; f = 1'b0; n = 1'b0;
  endtask

  logic [1:0] sig_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    tick(); tick();
    chk("reset_vals", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Power-up hold in S_RESET
    rst = 1'b0;
    tick();
    chk("t1_reset_hold_first", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    chk("t1_reset_hold_last", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t1_enter_sig_sel", 3'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Signal index stepping with wrap, then confirm
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b0, 1'b1);
      chk($sformatf("t2_sig_step%0d", i), 3'd1, sig_seq[i], 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    press(1'b1, 1'b0, 1'b0);
    chk("t2_sig_show", 3'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    tick();
    press(1'b0, 1'b1, 1'b0);
    repeat (6) tick();
    chk("t2_show_hold_btn_ignored", 3'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t2_enter_frq_sel", 3'd3, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);

    // Frequency stepping to 7, then simultaneous confirm + step
    for (int i = 1; i <= 7; i++) begin
      press(1'b0, 1'b0, 1'b1);
      chk($sformatf("t3_frq_step%0d", i), 3'd3, 2'd1, 3'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    press(1'b0, 1'b1, 1'b1);
    chk("t3_confirm_wins", 3'd4, 2'd1, 3'd7, 1'b0, 1'b0, 1'b1);
    repeat (9) tick();
    chk("t3_frq_show_hold", 3'd4, 2'd1, 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t3_run_load", 3'd5, 2'd1, 3'd7, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t3_load_drop", 3'd5, 2'd1, 3'd7, 1'b1, 1'b0, 1'b0);

    // Re-entry from run
    press(1'b0, 1'b0, 1'b1);
    chk("t4_next_ignored_run", 3'd5, 2'd1, 3'd7, 1'b1, 1'b0, 1'b0);
    tick();
    press(1'b1, 1'b1, 1'b0);
    chk("t4_both_to_sig_sel", 3'd1, 2'd1, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    press(1'b0, 1'b1, 1'b0);
    chk("t4_frq_ignored_sig_sel", 3'd1, 2'd1, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    press(1'b0, 1'b0, 1'b1);
    chk("t4_step_resumes", 3'd1, 2'd2, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    press(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t4_back_frq_sel", 3'd3, 2'd2, 3'd7, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("t4_frq_wrap", 3'd3, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    press(1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    chk("t4_run_again", 3'd5, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    press(1'b0, 1'b1, 1'b0);
    chk("t4_frq_alone", 3'd3, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Async reset mid-hold, with signal_select held through release
    press(1'b0, 1'b1, 1'b0);
    chk("t6_frq_show", 3'd4, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    rst = 1'b1;
    s = 1'b1;
    #1;
    chk("t6_async_reset", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    rst = 1'b0;
    repeat (9) tick();
    chk("t6_full_reset_hold", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t6_sig_sel", 3'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t5_held_no_edge", 3'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    s = 1'b0;
    tick();
    s = 1'b1;
    tick();
    chk("t5_new_edge", 3'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    s = 1'b0;

    for (int k = 0; k < 5 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
